seq_loop_profiler: RTL and testbench

SEQ_LOOP_PROFILER -- requirements
Module: seq_loop_profiler

---
 rtl/seq_loop_profiler_if.sv | 37 +++
 rtl/seq_loop_profiler.sv | 206 ++++++++++++++++++++
 tb/tb_seq_loop_profiler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_loop_profiler_if.sv
// Probe and record-stream bundle for the loop profiler.
// The profiler sits on the master side. It samples the probed module's
// handshake and state, and it sources the record stream.
interface seq_loop_profiler_if #(
  parameter int STATE_W = 76,
  parameter int CNT_W   = 32
);
  logic               ap_start;
  logic               ap_done;
  logic [STATE_W-1:0] cur_state;
  logic [STATE_W-1:0] iter_start_mask;
  logic [STATE_W-1:0] iter_end_mask;
  logic [STATE_W-1:0] post_loop_mask;
  logic               rec_valid;
  logic               rec_ready;
  logic               rec_kind;
  logic [CNT_W-1:0]   rec_cycles;
  logic [CNT_W-1:0]   rec_iters;
  logic               overflow;
  logic               busy;

  modport master (
    input  ap_start, ap_done, cur_state,
    input  iter_start_mask, iter_end_mask, post_loop_mask,
    input  rec_ready,
    output rec_valid, rec_kind, rec_cycles, rec_iters,
    output overflow, busy
  );

  modport slave (
    output ap_start, ap_done, cur_state,
    output iter_start_mask, iter_end_mask, post_loop_mask,
    output rec_ready,
    input  rec_valid, rec_kind, rec_cycles, rec_iters,
    input  overflow, busy
  );
endinterface

// File: rtl/seq_loop_profiler.sv
// Loop/latency profiler for a one-hot FSM.
// The block watches a probed module from ap_start to ap_done. It produces one
// record for every loop activation and one record for the whole run. Records
// go into a small first-word-fall-through FIFO. When that FIFO overflows, the
// record is dropped and a sticky flag is set.
module seq_loop_profiler #(
  parameter int STATE_W    = 76,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clock,
  input logic                 reset,
  seq_loop_profiler_if.master bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LOOP,
    FLUSH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic hit_start;
  logic hit_end;
  logic hit_post;

  logic [CNT_W-1:0] mcyc;
  logic [CNT_W-1:0] lcyc;
  logic [CNT_W-1:0] liter;

  logic             push;
  logic             push_kind;
  logic [CNT_W-1:0] push_cycles;
  logic [CNT_W-1:0] push_iters;
  logic             mod_clear;
  logic             loop_clear;

  logic             mem_kind   [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_cycles [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_iters  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occupancy;
  logic             fifo_full;
  logic             fifo_valid;
  logic             pop;
  logic             do_push;
  logic             drop;
  logic             overflow_q;

  // Counters stop at all-ones, so a very long run cannot wrap back to a small value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign hit_start = |(bus.cur_state & bus.iter_start_mask);
  assign hit_end   = |(bus.cur_state & bus.iter_end_mask);
  assign hit_post  = |(bus.cur_state & bus.post_loop_mask);

  // State register for the profiler FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ap_done outranks loop entry and loop exit, so a run that finishes inside a loop still ends cleanly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ap_start) state_d = RUN;
      RUN: begin
        if (bus.ap_done)    state_d = IDLE;
        else if (hit_start) state_d = LOOP;
      end
      LOOP: begin
        if (bus.ap_done)    state_d = FLUSH;
        else if (hit_post)  state_d = RUN;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Record pushes and counter clears.
  // A record counts the edge it is pushed on, so it reports the counter value plus one.
  always_comb begin
    push        = 1'b0;
    push_kind   = 1'b0;
    push_cycles = '0;
    push_iters  = '0;
    mod_clear   = 1'b0;
    loop_clear  = 1'b0;
    case (state_q)
      IDLE: mod_clear = bus.ap_start;
      RUN: begin
        if (bus.ap_done) begin
          push        = 1'b1;
          push_kind   = 1'b1;
          push_cycles = sat_inc(mcyc);
        end else if (hit_start) begin
          loop_clear = 1'b1;
        end
      end
      LOOP: begin
        if (bus.ap_done || hit_post) begin
          push        = 1'b1;
          push_cycles = sat_inc(lcyc);
          push_iters  = hit_end ? sat_inc(liter) : liter;
        end
      end
      FLUSH: begin
        push        = 1'b1;
        push_kind   = 1'b1;
        push_cycles = sat_inc(mcyc);
      end
      default: ;
    endcase
  end

  // Module cycle counter: cleared when a run starts, then counts every busy cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcyc <= '0;
    end else if (mod_clear) begin
      mcyc <= '0;
    end else if (state_q != IDLE) begin
      mcyc <= sat_inc(mcyc);
    end
  end

  // Loop cycle and iteration counters: cleared on loop entry, advanced only while inside the loop.
  always_ff @(posedge clock) begin
    if (reset) begin
      lcyc  <= '0;
      liter <= '0;
    end else if (loop_clear) begin
      lcyc  <= '0;
      liter <= '0;
    end else if (state_q == LOOP) begin
      lcyc <= sat_inc(lcyc);
      if (hit_end) liter <= sat_inc(liter);
    end
  end

  assign fifo_valid = (occupancy != '0);
  assign fifo_full  = (occupancy == OCC_FULL);
  assign pop        = fifo_valid && bus.rec_ready;
  assign do_push    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  // Record storage: no reset is needed because occupancy decides what is visible.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_kind[wr_ptr]   <= push_kind;
      mem_cycles[wr_ptr] <= push_cycles;
      mem_iters[wr_ptr]  <= push_iters;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Sticky overflow: once any record is lost, the flag stays set until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.rec_valid  = fifo_valid;
  assign bus.rec_kind   = fifo_valid ? mem_kind[rd_ptr]   : 1'b0;
  assign bus.rec_cycles = fifo_valid ? mem_cycles[rd_ptr] : '0;
  assign bus.rec_iters  = fifo_valid ? mem_iters[rd_ptr]  : '0;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_seq_loop_profiler.sv
// Testbench for seq_loop_profiler.
// A timestamp-based reference model tracks the expected records and the
// expected flags. Directed scenarios come first, then randomized traffic.
module tb_seq_loop_profiler;

  localparam int STATE_W = 8;
  localparam int CNT_W   = 32;
  localparam int DEPTH   = 4;
  localparam logic [7:0] START_MASK = 8'h02;
  localparam logic [7:0] END_MASK   = 8'h08;
  localparam logic [7:0] POST_MASK  = 8'h01;

  logic clock;
  logic reset;

  seq_loop_profiler_if #(.STATE_W(STATE_W), .CNT_W(CNT_W)) bus ();

  seq_loop_profiler #(
    .STATE_W   (STATE_W),
    .CNT_W     (CNT_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit              kind;
    longint unsigned cycles;
    longint unsigned iters;
  } rec_t;

  typedef enum {M_IDLE, M_RUN, M_LOOP, M_FLUSH} mode_t;

  rec_t            mq[$];
  mode_t           mmode;
  longint unsigned edge_no;
  longint unsigned t_mod;
  longint unsigned t_loop;
  longint unsigned iter_hits;
  bit              movf;

  int errors = 0;
  int checks = 0;

  logic [7:0] cs_table [8] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h08, 8'h10};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The reference works from timestamps: record cycles are the differences between edge numbers.
  task automatic modelEdge(input bit rst, input bit st, input bit dn, input logic [7:0] cs, input bit rdy);
    bit   hs;
    bit   he;
    bit   hp;
    bit   pop;
    bit   full;
    bit   push;
    rec_t r;
    hs = (cs & START_MASK) != 8'h00;
    he = (cs & END_MASK) != 8'h00;
    hp = (cs & POST_MASK) != 8'h00;
    edge_no++;
    if (rst) begin
      mq.delete();
      mmode = M_IDLE;
      movf  = 1'b0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      full = (mq.size() == DEPTH);
      push = 1'b0;
      r    = '{kind: 1'b0, cycles: 0, iters: 0};
      case (mmode)
        M_IDLE: if (st) begin
          mmode = M_RUN;
          t_mod = edge_no;
        end
        M_RUN: begin
          if (dn) begin
            push  = 1'b1;
            r     = '{kind: 1'b1, cycles: edge_no - t_mod, iters: 0};
            mmode = M_IDLE;
          end else if (hs) begin
            mmode     = M_LOOP;
            t_loop    = edge_no;
            iter_hits = 0;
          end
        end
        M_LOOP: begin
          if (dn || hp) begin
            push  = 1'b1;
            r     = '{kind: 1'b0, cycles: edge_no - t_loop, iters: iter_hits + (he ? 1 : 0)};
            mmode = dn ? M_FLUSH : M_RUN;
          end else if (he) begin
            iter_hits++;
          end
        end
        M_FLUSH: begin
          push  = 1'b1;
          r     = '{kind: 1'b1, cycles: edge_no - t_mod, iters: 0};
          mmode = M_IDLE;
        end
        default: mmode = M_IDLE;
      endcase
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (full && !pop) movf = 1'b1;
        else mq.push_back(r);
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("rec_valid", 64'(bus.rec_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkOutput("rec_kind", 64'(bus.rec_kind), 64'(mq[0].kind));
      checkOutput("rec_cycles", 64'(bus.rec_cycles), 64'(mq[0].cycles));
      checkOutput("rec_iters", 64'(bus.rec_iters), 64'(mq[0].iters));
    end else begin
      checkOutput("rec_kind_idle", 64'(bus.rec_kind), 64'(0));
      checkOutput("rec_cycles_idle", 64'(bus.rec_cycles), 64'(0));
      checkOutput("rec_iters_idle", 64'(bus.rec_iters), 64'(0));
    end
    checkOutput("overflow", 64'(bus.overflow), 64'(movf));
    checkOutput("busy", 64'(bus.busy), 64'(mmode != M_IDLE));
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input bit dn, input logic [7:0] cs, input bit rdy);
    reset         = rst;
    bus.ap_start  = st;
    bus.ap_done   = dn;
    bus.cur_state = cs;
    bus.rec_ready = rdy;
    modelEdge(rst, st, dn, cs, rdy);
    @(posedge clock);
    #1;
    compareAll();
  endtask

  task automatic tick(input logic [7:0] cs, input bit rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, cs, rdy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // A run without a loop: start, gap idle cycles, then done; reported cycles are gap + 1.
  task automatic doRun(input int gap, input bit rdy);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, rdy);
    for (int g = 0; g < gap; g++) tick(8'h00, rdy);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, rdy);
  endtask

  task automatic checkHead(input string tag, input bit kind, input int cyc, input int its);
    checkOutput({tag, "_valid"}, 64'(bus.rec_valid), 64'(1));
    checkOutput({tag, "_kind"}, 64'(bus.rec_kind), 64'(kind));
    checkOutput({tag, "_cycles"}, 64'(bus.rec_cycles), 64'(cyc));
    checkOutput({tag, "_iters"}, 64'(bus.rec_iters), 64'(its));
  endtask

  initial begin
    logic [7:0] seq42 [13];
    int         popped;
    bit         rst;
    bit         st;
    bit         dn;
    bit         rdy;
    logic [7:0] cs;

    reset               = 1'b1;
    bus.ap_start        = 1'b0;
    bus.ap_done         = 1'b0;
    bus.cur_state       = '0;
    bus.rec_ready       = 1'b0;
    bus.iter_start_mask = START_MASK;
    bus.iter_end_mask   = END_MASK;
    bus.post_loop_mask  = POST_MASK;
    mmode     = M_IDLE;
    edge_no   = 0;
    t_mod     = 0;
    t_loop    = 0;
    iter_hits = 0;
    movf      = 1'b0;

    // Reset state.
    doReset();
    checkOutput("reset_valid", 64'(bus.rec_valid), 64'(0));
    checkOutput("reset_busy", 64'(bus.busy), 64'(0));
    checkOutput("reset_overflow", 64'(bus.overflow), 64'(0));
    checkOutput("reset_cycles", 64'(bus.rec_cycles), 64'(0));

    // Loop entered at edge 2, ends at 4/6/8, exits at 9, and ap_done comes at 12.
    seq42 = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h08, 8'h00, 8'h08, 8'h00, 8'h08, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int e = 0; e < 13; e++) begin
      applyStimulus(1'b0, e == 0, e == 12, seq42[e], 1'b1);
      if (e == 9)  checkHead("loop_rec", 1'b0, 7, 3);
      if (e == 12) checkHead("mod_rec", 1'b1, 12, 0);
    end
    checkOutput("s42_busy_end", 64'(bus.busy), 64'(0));

    // ap_done arrives while inside the loop.
    doReset();
    for (int e = 0; e < 7; e++) begin
      applyStimulus(1'b0, e == 0, e == 5, (e == 2) ? 8'h02 : 8'h00, 1'b1);
      if (e == 5) begin
        checkHead("flush_loop", 1'b0, 3, 0);
        checkOutput("flush_busy5", 64'(bus.busy), 64'(1));
      end
      if (e == 6) begin
        checkHead("flush_mod", 1'b1, 6, 0);
        checkOutput("flush_busy7", 64'(bus.busy), 64'(0));
      end
    end

    // Six runs with the consumer stalled: the fifth run overflows, and the first four survive.
    doReset();
    for (int i = 1; i <= 6; i++) begin
      doRun(i, 1'b0);
      if (i == 4) checkOutput("ovf_after4", 64'(bus.overflow), 64'(0));
      if (i == 5) checkOutput("ovf_after5", 64'(bus.overflow), 64'(1));
      tick(8'h00, 1'b0);
    end
    for (int i = 1; i <= 4; i++) begin
      checkHead("drain", 1'b1, i + 1, 0);
      tick(8'h00, 1'b1);
    end
    checkOutput("drain_empty", 64'(bus.rec_valid), 64'(0));

    // Full FIFO with a push and a pop on the same edge: nothing is lost.
    doReset();
    for (int i = 1; i <= 4; i++) doRun(1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("pp_overflow", 64'(bus.overflow), 64'(0));
    popped = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.rec_valid) popped++;
      tick(8'h00, 1'b1);
    end
    checkOutput("pp_occupancy", 64'(popped), 64'(4));

    // Reset during a loop with two records queued: everything is discarded.
    doReset();
    doRun(2, 1'b0);
    doRun(3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(8'h00, 1'b0);
    tick(8'h02, 1'b0);
    tick(8'h08, 1'b0);
    checkOutput("pre_reset_busy", 64'(bus.busy), 64'(1));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("mid_reset_valid", 64'(bus.rec_valid), 64'(0));
    checkOutput("mid_reset_busy", 64'(bus.busy), 64'(0));
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, k[0], cs_table[k], 1'b1);
      checkOutput("post_reset_quiet", 64'(bus.rec_valid), 64'(0));
    end

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      st  = ($urandom_range(0, 3) == 0);
      dn  = ($urandom_range(0, 11) == 0);
      cs  = cs_table[$urandom_range(0, 7)];
      rdy = (n % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      applyStimulus(rst, st, dn, cs, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
